point_dispatcher: RTL
=====================

Name: point_dispatcher

Overview:
Frame-level scheduler that drives the per-pixel iteration calculator. It walks every pixel of the screen in raster order and, for each one, issues a start pulse with x/y. It then waits for the calculator's done, saturates the returned iteration count, and writes it to the frame buffer through a valid/ready write port. It sits between the top-level control (go) and the iteration calculator / frame buffer pair.

Parameters:
H_RES, 640, pixels per line; x counts 0..H_RES-1
V_RES, 480, lines per frame; y counts 0..V_RES-1
HBI, 32, width of the calculator iteration bus
DATA_W, 8, frame-buffer pixel width
ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES
TIMEOUT, 4096, max cycles to wait for calc_done before forcing a saturated pixel

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
go  in  1  request one full frame; sampled only in IDLE
calc_start  out  1  one-cycle start pulse to the calculator
calc_x  out  12  pixel column, stable from calc_start until the pixel is written
calc_y  out  12  pixel row, same stability rule
calc_done  in  1  calculator done level
calc_iteration  in  HBI  calculator result, valid while calc_done=1
wr_valid  out  1  frame-buffer write request
wr_ready  in  1  frame-buffer accepts when wr_valid & wr_ready
wr_addr  out  ADDR_W  linear address y*H_RES+x
wr_data  out  DATA_W  saturated iteration count
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse after the last pixel write is accepted
timeout_err  out  1  sticky per frame; set if any pixel timed out, cleared on go acceptance

Behaviour:
- Reset (RST=1 at an edge): state=IDLE. calc_start=0, calc_x=0, calc_y=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, timeout_err=0, and the timeout counter is cleared. Reset mid-frame abandons the frame with no further writes. A pending wr_valid drops on that edge.
- States: IDLE, ISSUE, SETTLE, WAIT, WRITE.
- IDLE: on go=1, clear x, y, addr and timeout_err, then go to ISSUE. go is ignored in every other state.
- ISSUE: calc_start=1 for exactly this cycle, then go to SETTLE.
- SETTLE: one cycle with calc_done ignored. The calculator's done is registered and is still high from the previous pixel on the edge where start is accepted. Clear the timeout counter and go to WAIT.
- WAIT: increment the timeout counter each cycle.
  - On calc_done=1: latch wr_data = min(calc_iteration, 2^DATA_W-1) and go to WRITE.
  - If the counter reaches TIMEOUT-1 with calc_done still 0: latch wr_data = 2^DATA_W-1, set timeout_err, and go to WRITE.
- WRITE: wr_valid=1 and wr_addr/wr_data are held until wr_valid & wr_ready at an edge. On acceptance:
  - If x = H_RES-1 and y = V_RES-1: frame_done=1 for one cycle, go to IDLE.
  - Else if x = H_RES-1: x=0, y+1, addr+1, go to ISSUE.
  - Else: x+1, addr+1, go to ISSUE.
- wr_addr comes from a running counter. No multiplier is used.
- calc_x/calc_y never change between a calc_start and the acceptance of that pixel's write.
- Minimum per-pixel latency: ISSUE + SETTLE + 1 WAIT cycle + 1 WRITE cycle = 4 cycles, when calc_done is already high on the first WAIT cycle and wr_ready=1.
- frame_done and go in the same cycle: frame_done pulses from WRITE. go is only seen on the following IDLE cycle if still held.
- calc_done and timeout on the same cycle: calc_done wins and timeout_err is not set.

Test Plan:
- H_RES=4, V_RES=3, wr_ready=1, calculator model returns iteration=x+10*y after 5 cycles, go pulse → 12 writes at addr 0..11 with data 0,1,2,3,10,11,12,13,20,21,22,23. frame_done pulses once, one cycle after the write to addr 11. busy=0 afterwards.
- Model returns iteration=300 with DATA_W=8 → every wr_data=255. Model returns 254 → wr_data=254.
- Model holds calc_done=1 permanently from the previous pixel → each pixel still waits through SETTLE. Exactly one calc_start per write. No pixel is skipped or written twice.
- wr_ready=0 for 7 cycles during the write of pixel (2,1) → wr_valid, wr_addr=6, wr_data and calc_x/calc_y stay stable. No calc_start is issued until acceptance.
- TIMEOUT=16, model never raises done for pixel (1,0) → write addr 1 with data 255 on the 16th WAIT cycle. timeout_err=1 until the next accepted go.
- RST=1 while in WAIT at pixel (3,2), then go → no write for (3,2). Outputs return to reset values. The next frame restarts at addr 0, x=0, y=0.

Source files
------------

// File: rtl/point_dispatcher.sv
// Frame-level pixel scheduler. It walks the screen in raster order. For each pixel it
// starts the iteration calculator, waits for its result (or a timeout), saturates the
// result and writes it to the frame buffer over a valid/ready port.
module point_dispatcher #(
  parameter int unsigned H_RES   = 640,
  parameter int unsigned V_RES   = 480,
  parameter int unsigned HBI     = 32,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              go,
  output logic              calc_start,
  output logic [11:0]       calc_x,
  output logic [11:0]       calc_y,
  input  logic              calc_done,
  input  logic [HBI-1:0]    calc_iteration,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [11:0]     XLast   = 12'(H_RES - 1);
  localparam logic [11:0]     YLast   = 12'(V_RES - 1);
  localparam logic [TW-1:0]   CntLast = TW'(TIMEOUT - 1);
  localparam logic [HBI-1:0]  IterMax = HBI'({DATA_W{1'b1}});

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StSettle,
    StWait,
    StWrite
  } state_e;

  state_e              state_q, state_d;
  logic [11:0]         x_q, x_d;
  logic [11:0]         y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [TW-1:0]       cnt_q, cnt_d;
  logic                terr_q, terr_d;
  logic                fdone_q, fdone_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      terr_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      terr_q  <= terr_d;
      fdone_q <= fdone_d;
    end
  end

  // Next-state logic: raster walk, calculator handshake, timeout and write acceptance.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    terr_d  = terr_q;
    fdone_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          terr_d  = 1'b0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StSettle;
      end
      StSettle: begin
        // The calculator's done may still be high from the previous pixel here.
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + TW'(1);
        if (calc_done) begin
          data_d  = (calc_iteration > IterMax) ? {DATA_W{1'b1}} : calc_iteration[DATA_W-1:0];
          state_d = StWrite;
        end else if (cnt_q == CntLast) begin
          data_d  = {DATA_W{1'b1}};
          terr_d  = 1'b1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (wr_ready) begin
          if (x_q == XLast && y_q == YLast) begin
            fdone_d = 1'b1;
            state_d = StIdle;
          end else if (x_q == XLast) begin
            x_d     = '0;
            y_d     = y_q + 12'd1;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StIssue;
          end else begin
            x_d     = x_q + 12'd1;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StIssue;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from state or taken straight from registers.
  always_comb begin
    calc_start  = (state_q == StIssue);
    wr_valid    = (state_q == StWrite);
    busy        = (state_q != StIdle);
    calc_x      = x_q;
    calc_y      = y_q;
    wr_addr     = addr_q;
    wr_data     = data_q;
    frame_done  = fdone_q;
    timeout_err = terr_q;
  end

endmodule
